pipelined_ripple_adder: RTL and testbench

- Parametrised, pipelined successor of the 4-bit ripple-carry adder.
- Operand width is split into STAGES equal chunks. Each chunk is added by a combinational ripple chain in its own pipeline stage; carry is registered between stages.
- Streaming valid/ready interface on input and output. Full throughput of one operation per cycle, with backpressure.
- Used as the arithmetic core for wide adders where a single-cycle carry chain misses timing.

---
 rtl/pipelined_adder_pkg.sv | 16 +
 rtl/ripple_chunk_adder.sv | 27 ++
 rtl/pipelined_ripple_adder.sv | 154 +++++++++++++++
 tb/tb_pipelined_ripple_adder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined ripple adder: chunk sizing and configuration legality.
// Purely elaboration-time content; no logic, no latency.
// Backpressure: not applicable.
package pipelined_adder_pkg;

   // Bits added by each pipeline stage.
   function automatic int chunk_width(input int data_width, input int stages);
      return data_width / stages;
   endfunction

   // Width must split evenly into 1..DATA_WIDTH stages.
   function automatic bit cfg_ok(input int data_width, input int stages);
      return (stages >= 1) && (stages <= data_width) && ((data_width % stages) == 0);
   endfunction

endpackage

// File: rtl/ripple_chunk_adder.sv
// Combinational WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports a, b, ci in; s, co out. Carry ripples bit 0 to bit WIDTH-1.
module ripple_chunk_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   // Carry held in a block-local variable so the chain is a single sequential
   // evaluation rather than a self-referencing vector.
   always_comb begin : p_ripple
      logic c;
      s = '0;
      c = ci;
      for (int i = 0; i < WIDTH; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      co = c;
   end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined DATA_WIDTH adder: STAGES ripple chunks, carry registered between stages.
// Latency: STAGES register stages (accept at edge n -> out_valid after edge n+STAGES-1).
// Backpressure: valid/ready; bubbles squeezed, in_ready drops only when every stage is full and stalled.
// Ports: clk, rst_n (async active-low); in_a/in_b/in_ci/in_valid -> in_ready;
//        out_s/out_co/out_valid <- out_ready.
// Optional macro PIPELINED_RIPPLE_ADDER_SUB_EN adds in_sub (a-b) and out_ovf (signed overflow).
module pipelined_ripple_adder
   import pipelined_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic                  in_ci,
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
   input  logic                  in_sub,
   output logic                  out_ovf,
`endif
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_s,
   output logic                  out_co,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int CHUNK = chunk_width(DATA_WIDTH, STAGES);
   localparam int LAST  = STAGES - 1;

   if (!cfg_ok(DATA_WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_ripple_adder: DATA_WIDTH must be divisible by STAGES (1..DATA_WIDTH)");
   end

   // Per-stage record: sum holds chunks 0..k once stage k is loaded; operand
   // bits below chunk k+1 are dead after that and get trimmed by synthesis.
   typedef struct packed {
      logic                  vld;
      logic                  cy;
      logic [DATA_WIDTH-1:0] sum;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
   } stage_t;

   stage_t st_q [STAGES];
   stage_t st_d [STAGES];
   stage_t up   [STAGES];   // what feeds each stage: inputs for 0, previous stage otherwise

   logic [STAGES-1:0]            load;
   logic [STAGES-1:0][CHUNK-1:0] s_chunk;
   logic [STAGES-1:0]            co_chunk;

   // Operand conditioning at the pipe entry.
   logic [DATA_WIDTH-1:0] b_in;
   logic                  ci_in;
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
   assign b_in  = in_sub ? ~in_b : in_b;
   assign ci_in = in_sub ? 1'b1  : in_ci;
`else
   assign b_in  = in_b;
   assign ci_in = in_ci;
`endif

   always_comb begin
      up[0]     = '0;
      up[0].vld = in_valid;
      up[0].cy  = ci_in;
      up[0].a   = in_a;
      up[0].b   = b_in;
      for (int k = 1; k < STAGES; k++) begin
         up[k] = st_q[k-1];
      end
   end

   // A stage may load if it, or any stage after it, is empty, or the output
   // is being consumed. Walking back from the output keeps this one pass.
   always_comb begin : p_load
      logic r;
      load = '0;
      r    = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         r       = !st_q[k].vld | r;
         load[k] = r;
      end
   end

   assign in_ready = load[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      ripple_chunk_adder #(
         .WIDTH (CHUNK)
      ) u_add (
         .a  (up[k].a[k*CHUNK +: CHUNK]),
         .b  (up[k].b[k*CHUNK +: CHUNK]),
         .ci (up[k].cy),
         .s  (s_chunk[k]),
         .co (co_chunk[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         st_d[k]                        = up[k];
         st_d[k].sum[k*CHUNK +: CHUNK] = s_chunk[k];
         st_d[k].cy                     = co_chunk[k];
      end
   end

   // Data is only captured alongside a valid token; an empty token just clears vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            st_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               if (up[k].vld) begin
                  st_q[k] <= st_d[k];
               end else begin
                  st_q[k].vld <= 1'b0;
               end
            end
         end
      end
   end

   assign out_valid = st_q[LAST].vld;
   assign out_s     = st_q[LAST].sum;
   assign out_co    = st_q[LAST].cy;

`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
   // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
   logic msb_cin;
   logic ovf_q;
   logic ovf_d;

   assign msb_cin = up[LAST].a[DATA_WIDTH-1] ^ up[LAST].b[DATA_WIDTH-1] ^ s_chunk[LAST][CHUNK-1];
   assign ovf_d   = msb_cin ^ co_chunk[LAST];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (load[LAST] && up[LAST].vld) begin
         ovf_q <= ovf_d;
      end
   end

   assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder: 8-bit/4-stage and 32-bit/1-stage instances.
// Table vectors, hand-written pipeline sequences, and a randomized scoreboard run.
// Summary line reports comparison and failure counts.
module tb_pipelined_ripple_adder;

   localparam int DW = 8;
   localparam int ST = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [DW-1:0] in_a, in_b, out_s;
   logic          in_ci, in_valid, in_ready, out_co, out_valid, out_ready;
   logic          in_sub;
   logic          out_ovf;

   logic [31:0]   w_in_a, w_in_b, w_out_s;
   logic          w_in_ci, w_in_valid, w_in_ready, w_out_co, w_out_valid, w_out_ready;
   logic          w_in_sub;
   logic          w_out_ovf;

   pipelined_ripple_adder #(.DATA_WIDTH(DW), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ci     (in_ci),
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
      .in_sub    (in_sub),
      .out_ovf   (out_ovf),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_s     (out_s),
      .out_co    (out_co),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   pipelined_ripple_adder #(.DATA_WIDTH(32), .STAGES(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_a      (w_in_a),
      .in_b      (w_in_b),
      .in_ci     (w_in_ci),
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
      .in_sub    (w_in_sub),
      .out_ovf   (w_out_ovf),
`endif
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .out_s     (w_out_s),
      .out_co    (w_out_co),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready)
   );

`ifndef PIPELINED_RIPPLE_ADDER_SUB_EN
   assign out_ovf   = 1'b0;
   assign w_out_ovf = 1'b0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       sub;
      logic [7:0] s;
      logic       co;
      logic       ovf;
   } vec_t;

   vec_t tbl[8];
   vec_t sub_tbl[2];

   logic [9:0] exp_q[$];   // {ovf, co, s}
   int   cyc, emit_cnt, acc_cnt, rdy_drop, held_bad, first_emit, last_emit;
   logic [7:0] held_s;
   bit   holding;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic sub);
      int ua, ub, sa, sb, total, sres;
      logic [9:0] r;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      if (sub) begin
         total = ua - ub + 256;
         sres  = sa - sb;
      end else begin
         total = ua + ub + int'(ci);
         sres  = sa + sb + int'(ci);
      end
      r[7:0] = total[7:0];
      r[8]   = total[8];
      r[9]   = (sres > 127) || (sres < -128);
      return r;
   endfunction

   task automatic clr();
      emit_cnt = 0; acc_cnt = 0; rdy_drop = 0; held_bad = 0;
      first_emit = 0; last_emit = 0; holding = 0;
   endtask

   // One clock: observe at negedge, update scoreboard, return at posedge+1.
   task automatic step();
      logic [9:0] e;
      @(negedge clk);
      cyc++;
      if (in_valid && !in_ready) rdy_drop++;
      if (out_valid && !out_ready) begin
         if (holding && (out_s !== held_s)) held_bad++;
         holding = 1;
         held_s  = out_s;
      end else begin
         holding = 0;
      end
      if (out_valid && out_ready) begin
         emit_cnt++;
         if (emit_cnt == 1) first_emit = cyc;
         last_emit = cyc;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_output: got s=%0h with nothing outstanding, expected none", out_s);
         end else begin
            e = exp_q.pop_front();
            check("sb_s", 32'(out_s), 32'(e[7:0]));
            check("sb_co", 32'(out_co), 32'(e[8]));
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
            check("sb_ovf", 32'(out_ovf), 32'(e[9]));
`endif
         end
      end
      if (in_valid && in_ready) begin
         acc_cnt++;
         exp_q.push_back(model(in_a, in_b, in_ci, in_sub));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      bit seen;
      in_a = v.a; in_b = v.b; in_ci = v.ci; in_sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat  = 0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
         else begin
            @(posedge clk);
            lat++;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: out_valid never rose, expected after %0d edges", tag, ST - 1);
      end else begin
         check({tag, "_lat"}, 32'(lat), 32'(ST - 1));
         check({tag, "_s"}, 32'(out_s), 32'(v.s));
         check({tag, "_co"}, 32'(out_co), 32'(v.co));
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
         check({tag, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
`endif
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[1] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
      tbl[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[6] = '{8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[7] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      sub_tbl[0] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      sub_tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};

      rst_n = 1'b0;
      in_a = '0; in_b = '0; in_ci = 1'b0; in_sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      w_in_a = '0; w_in_b = '0; w_in_ci = 1'b0; w_in_sub = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
      cyc = 0;
      clr();

      // Reset state
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_s", 32'(out_s), 32'd0);
      check("rst_out_co", 32'(out_co), 32'd0);
      check("rst_w_out_valid", 32'(w_out_valid), 32'd0);
      check("rst_w_out_s", w_out_s, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Table vectors, one at a time
      for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
      for (int i = 0; i < 2; i++) run_vec(sub_tbl[i], $sformatf("subvec%0d", i));
`endif
      in_sub = 1'b0;

      // Back-to-back: 16 transactions, out_ready high
      clr();
      exp_q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_a = 8'(i); in_b = 8'(2 * i); in_ci = i[0]; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      for (int i = 0; i < ST + 2; i++) step();
      check("b2b_emits", 32'(emit_cnt), 32'd16);
      check("b2b_contiguous", 32'(last_emit - first_emit), 32'd15);
      check("b2b_in_ready_drops", 32'(rdy_drop), 32'd0);
      check("b2b_left", 32'(exp_q.size()), 32'd0);

      // Backpressure: out_ready low for 10 cycles with in_valid high
      clr();
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_a = 8'(8'hF0 + i); in_b = 8'(8'h13 * i); in_ci = ~i[0]; in_valid = 1'b1;
         step();
      end
      check("bp_accepted", 32'(acc_cnt), 32'(ST));
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_head_stable", 32'(held_bad), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < ST + 4; i++) step();
      check("bp_drained", 32'(emit_cnt), 32'(ST));
      check("bp_left", 32'(exp_q.size()), 32'd0);

      // Reset mid-flight: 3 in the pipe, head stalled at the output
      clr();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_a = 8'(8'h40 + i); in_b = 8'h3C; in_ci = 1'b1; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      step();
      @(negedge clk);
      check("rf_pre_valid", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rf_out_valid", 32'(out_valid), 32'd0);
      check("rf_out_s", 32'(out_s), 32'd0);
      check("rf_out_co", 32'(out_co), 32'd0);
      exp_q.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      clr();
      out_ready = 1'b1;
      for (int i = 0; i < ST + 4; i++) step();
      check("rf_no_stale", 32'(emit_cnt), 32'd0);

      // Randomized traffic against the arithmetic model
      clr();
      exp_q.delete();
      for (int i = 0; i < 400; i++) begin
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         in_ci     = 1'($urandom_range(0, 1));
`ifdef PIPELINED_RIPPLE_ADDER_SUB_EN
         in_sub    = 1'($urandom_range(0, 1));
`endif
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < ST + 4; i++) step();
      check("rand_left", 32'(exp_q.size()), 32'd0);
      check("rand_hold_stable", 32'(held_bad), 32'd0);
      check("rand_emits_match", 32'(emit_cnt), 32'(acc_cnt));
      in_sub = 1'b0;

      // Single-stage 32-bit instance
      w_in_a = 32'h8000_0000; w_in_b = 32'h8000_0000; w_in_ci = 1'b1;
      w_in_valid = 1'b1; w_out_ready = 1'b1;
      @(negedge clk);
      check("s1_in_ready", 32'(w_in_ready), 32'd1);
      check("s1_pre_valid", 32'(w_out_valid), 32'd0);
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      @(negedge clk);
      check("s1_out_valid", 32'(w_out_valid), 32'd1);
      check("s1_out_s", w_out_s, 32'h0000_0001);
      check("s1_out_co", 32'(w_out_co), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("s1_drained", 32'(w_out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
